// File: rtl/movwide_pkg.sv
// -----------------------------------------------------------------------------
// movwide_pkg
// Shared definitions for the LEGv8 wide-move (MOVZ/MOVK) constant materializer:
// IM-format opcodes, field positions, FSM state type and small field helpers.
// -----------------------------------------------------------------------------
package movwide_pkg;

    localparam logic [8:0] OPC_MOVZ = 9'b110100101;
    localparam logic [8:0] OPC_MOVK = 9'b111100101;

    // IM-format field positions: opcode[31:23], hw[22:21], imm16[20:5], Rd[4:0]
    localparam int HW_LSB  = 21;
    localparam int IMM_LSB = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Select halfword idx of a 64-bit constant.
    function automatic logic [15:0] hw_slice(input logic [63:0] val, input logic [1:0] idx);
        logic [15:0] hw;
        case (idx)
            2'd0:    hw = val[15:0];
            2'd1:    hw = val[31:16];
            2'd2:    hw = val[47:32];
            2'd3:    hw = val[63:48];
            default: hw = 16'h0000;
        endcase
        return hw;
    endfunction

    // Mask of halfword positions strictly above idx.
    function automatic logic [3:0] above_mask(input logic [1:0] idx);
        logic [3:0] m;
        case (idx)
            2'd0:    m = 4'b1110;
            2'd1:    m = 4'b1100;
            2'd2:    m = 4'b1000;
            2'd3:    m = 4'b0000;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Assemble one IM-format instruction word.
    function automatic logic [31:0] im_word(input logic [8:0]  opc,
                                            input logic [1:0]  hw,
                                            input logic [15:0] imm,
                                            input logic [4:0]  rd);
        logic [31:0] w;
        w                   = 32'h0000_0000;
        w[31:23]            = opc;
        w[HW_LSB +: 2]      = hw;
        w[IMM_LSB +: 16]    = imm;
        w[4:0]              = rd;
        return w;
    endfunction

endpackage

// File: rtl/movwide_encoder_hw_next_sel.sv
// -----------------------------------------------------------------------------
// hw_next_sel
// Combinational priority selector over the non-zero halfword mask.
//   nz       : halfword mask (which halfwords are emitted)
//   index    : halfword currently being emitted
//   start    : 1 = search from halfword 0 inclusive (capture path),
//              0 = search strictly above index (advance path)
//   next_idx : lowest eligible set bit of nz
//   last     : no bit of nz above next_idx is set
// -----------------------------------------------------------------------------
module hw_next_sel
    import movwide_pkg::*;
(
    input  logic [3:0] nz,
    input  logic [1:0] index,
    input  logic       start,
    output logic [1:0] next_idx,
    output logic       last
);

    logic [3:0] cand_s;

    // Restrict the search window, then pick its lowest set bit.
    always_comb begin
        cand_s   = 4'b0000;
        next_idx = 2'd0;
        last     = 1'b1;
        if (start) begin
            cand_s = nz;
        end else begin
            cand_s = nz & above_mask(index);
        end
        casez (cand_s)
            4'b???1: next_idx = 2'd0;
            4'b??10: next_idx = 2'd1;
            4'b?100: next_idx = 2'd2;
            4'b1000: next_idx = 2'd3;
            default: next_idx = 2'd0;
        endcase
        last = ((nz & above_mask(next_idx)) == 4'b0000);
    end

endmodule

// File: rtl/movwide_encoder.sv
// -----------------------------------------------------------------------------
// movwide_encoder
// Turns a 64-bit constant plus destination register into the shortest
// MOVZ/MOVK sequence, one IM-format word per InstrValid/InstrReady handshake.
// Ports:
//   CLK, Reset          : clock, synchronous active-high reset
//   ValIn / RdyIn       : request handshake (BusVal, Rd captured on accept)
//   InstrOut            : encoded instruction (0 when InstrValid=0)
//   InstrValid/InstrReady : output handshake
//   InstrLast           : current word ends the sequence
//   Busy                : sequence in progress (== !RdyIn)
// Parameter SKIP_ZERO: 1 = skip zero halfwords, 0 = always emit all four.
// -----------------------------------------------------------------------------
module movwide_encoder
    import movwide_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        ValIn,
    output logic        RdyIn,
    input  logic [63:0] BusVal,
    input  logic [4:0]  Rd,
    output logic [31:0] InstrOut,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic        InstrLast,
    output logic        Busy
);

    state_t      state_r;
    logic [63:0] val_r;
    logic [4:0]  rd_r;
    logic [3:0]  nz_r;
    logic [1:0]  index_r;
    logic [31:0] instr_out_r;
    logic        instr_valid_r;
    logic        instr_last_r;

    logic [3:0]  nz_in_s;
    logic [3:0]  sel_nz_s;
    logic        sel_start_s;
    logic [1:0]  sel_idx_s;
    logic        sel_last_s;

    // Emission mask for an incoming constant; value 0 still needs one MOVZ.
    always_comb begin
        nz_in_s = 4'b0000;
        if (!SKIP_ZERO) begin
            nz_in_s = 4'b1111;
        end else begin
            nz_in_s = {(BusVal[63:48] != 16'h0000), (BusVal[47:32] != 16'h0000),
                       (BusVal[31:16] != 16'h0000), (BusVal[15:0]  != 16'h0000)};
            if (nz_in_s == 4'b0000) begin
                nz_in_s = 4'b0001;
            end else begin
                nz_in_s = nz_in_s;
            end
        end
    end

    // One selector serves both paths: in IDLE it finds the first halfword of
    // the incoming request, in EMIT it finds the successor of the current one.
    always_comb begin
        sel_nz_s    = nz_r;
        sel_start_s = 1'b0;
        if (state_r == IDLE) begin
            sel_nz_s    = nz_in_s;
            sel_start_s = 1'b1;
        end else begin
            sel_nz_s    = nz_r;
            sel_start_s = 1'b0;
        end
    end

    hw_next_sel u_hw_next_sel (
        .nz       (sel_nz_s),
        .index    (index_r),
        .start    (sel_start_s),
        .next_idx (sel_idx_s),
        .last     (sel_last_s)
    );

    // Sequencer: captures requests and pre-computes each registered output word.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r       <= IDLE;
            val_r         <= 64'h0;
            rd_r          <= 5'd0;
            nz_r          <= 4'b0000;
            index_r       <= 2'd0;
            instr_out_r   <= 32'h0;
            instr_valid_r <= 1'b0;
            instr_last_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ValIn) begin
                        val_r         <= BusVal;
                        rd_r          <= Rd;
                        nz_r          <= nz_in_s;
                        index_r       <= sel_idx_s;
                        instr_out_r   <= im_word(OPC_MOVZ, sel_idx_s,
                                                 hw_slice(BusVal, sel_idx_s), Rd);
                        instr_valid_r <= 1'b1;
                        instr_last_r  <= sel_last_s;
                        state_r       <= EMIT;
                    end
                end
                EMIT: begin
                    // Without InstrReady every output register simply holds.
                    if (InstrReady) begin
                        if (instr_last_r) begin
                            instr_out_r   <= 32'h0;
                            instr_valid_r <= 1'b0;
                            instr_last_r  <= 1'b0;
                            state_r       <= IDLE;
                        end else begin
                            index_r      <= sel_idx_s;
                            instr_out_r  <= im_word(OPC_MOVK, sel_idx_s,
                                                    hw_slice(val_r, sel_idx_s), rd_r);
                            instr_last_r <= sel_last_s;
                        end
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    instr_out_r   <= 32'h0;
                    instr_valid_r <= 1'b0;
                    instr_last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign RdyIn      = (state_r == IDLE);
    assign Busy       = (state_r != IDLE);
    assign InstrOut   = instr_out_r;
    assign InstrValid = instr_valid_r;
    assign InstrLast  = instr_last_r;

endmodule

// File: tb/tb_movwide_encoder.sv
// -----------------------------------------------------------------------------
// tb_movwide_encoder
// Drives directed and random constants into two encoders (SKIP_ZERO=1 and 0)
// and compares each emitted word against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_movwide_encoder;

    logic        clk;
    logic        reset;
    logic        val_a, val_b;
    logic [63:0] bus_val;
    logic [4:0]  rd;
    logic        instr_ready;

    logic        rdy_a, valid_a, last_a, busy_a;
    logic [31:0] out_a;
    logic        rdy_b, valid_b, last_b, busy_b;
    logic [31:0] out_b;

    // Observation mux: use_full selects the SKIP_ZERO=0 instance.
    logic        use_full;
    logic        o_rdy, o_valid, o_last, o_busy;
    logic [31:0] o_out;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    movwide_encoder #(.SKIP_ZERO(1'b1)) u_skip (
        .CLK(clk), .Reset(reset), .ValIn(val_a), .RdyIn(rdy_a),
        .BusVal(bus_val), .Rd(rd), .InstrOut(out_a), .InstrValid(valid_a),
        .InstrReady(instr_ready), .InstrLast(last_a), .Busy(busy_a)
    );

    movwide_encoder #(.SKIP_ZERO(1'b0)) u_full (
        .CLK(clk), .Reset(reset), .ValIn(val_b), .RdyIn(rdy_b),
        .BusVal(bus_val), .Rd(rd), .InstrOut(out_b), .InstrValid(valid_b),
        .InstrReady(instr_ready), .InstrLast(last_b), .Busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        o_rdy   = use_full ? rdy_b   : rdy_a;
        o_valid = use_full ? valid_b : valid_a;
        o_last  = use_full ? last_b  : last_a;
        o_busy  = use_full ? busy_b  : busy_a;
        o_out   = use_full ? out_b   : out_a;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: list of words, one per emitted halfword, lowest first.
    task automatic build_exp(input bit full, input logic [63:0] v, input logic [4:0] r);
        longint unsigned hw;
        longint unsigned w;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            hw = (v >> (16 * i)) & 64'hFFFF;
            if (full || hw != 0) begin
                w = (exp_q.size() == 0) ? 64'hD280_0000 : 64'hF280_0000;
                w = w + (longint'(i) << 21) + (hw << 5) + r;
                exp_q.push_back(w[31:0]);
            end
        end
        if (exp_q.size() == 0) exp_q.push_back(32'hD280_0000 + 32'(r));
    endtask

    task automatic set_val(input bit full, input logic v);
        if (full) val_b = v; else val_a = v;
    endtask

    // Issue one request and consume the whole sequence, optionally stalling
    // stall_cycles on word stall_word while poking ValIn with a decoy value.
    task automatic run_seq(input bit full, input logic [63:0] v, input logic [4:0] r,
                           input int stall_word, input int stall_cycles);
        int guard;
        logic [31:0] held;
        use_full = full;
        build_exp(full, v, r);
        guard = 0;
        while (!o_rdy && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("rdy_before_req", 64'(o_rdy), 64'd1);
        set_val(full, 1'b1);
        bus_val = v;
        rd      = r;
        instr_ready = 1'b1;
        @(posedge clk); #1;
        set_val(full, 1'b0);
        bus_val = 64'(unsigned'({$urandom, $urandom}));
        rd      = 5'($urandom);
        for (int k = 0; k < exp_q.size(); k++) begin
            check_eq("valid", 64'(o_valid), 64'd1);
            check_eq("busy", 64'(o_busy), 64'd1);
            check_eq("word", 64'(o_out), 64'(exp_q[k]));
            check_eq("last", 64'(o_last), 64'(k == exp_q.size() - 1));
            if (k == stall_word) begin
                held = o_out;
                instr_ready = 1'b0;
                set_val(full, 1'b1);
                for (int s = 0; s < stall_cycles; s++) begin
                    bus_val = 64'(unsigned'({$urandom, $urandom}));
                    @(posedge clk); #1;
                    check_eq("stall_word", 64'(o_out), 64'(held));
                    check_eq("stall_valid", 64'(o_valid), 64'd1);
                    check_eq("stall_last", 64'(o_last), 64'(k == exp_q.size() - 1));
                end
                set_val(full, 1'b0);
                instr_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        check_eq("valid_after", 64'(o_valid), 64'd0);
        check_eq("out_after", 64'(o_out), 64'd0);
        check_eq("rdy_after", 64'(o_rdy), 64'd1);
    endtask

    initial begin
        logic [63:0] rv;
        logic [15:0] h;
        reset = 1'b1; val_a = 1'b0; val_b = 1'b0; bus_val = 64'h0; rd = 5'd0;
        instr_ready = 1'b1; use_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 64'(valid_a), 64'd0);
        check_eq("rst_last", 64'(last_a), 64'd0);
        check_eq("rst_out", 64'(out_a), 64'd0);
        check_eq("rst_busy", 64'(busy_a), 64'd0);
        check_eq("rst_rdy", 64'(rdy_a), 64'd1);
        check_eq("rst_rdy_full", 64'(rdy_b), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Literal test-plan words, checked against constants directly.
        build_exp(1'b0, 64'h0, 5'd1);
        check_eq("plan_zero", 64'(exp_q[0]), 64'h0000_0000_D280_0001);
        run_seq(1'b0, 64'h0, 5'd1, -1, 0);
        run_seq(1'b0, 64'h0000_0000_0000_1234, 5'd2, -1, 0);
        run_seq(1'b0, 64'h0001_0000_0000_0000, 5'd0, -1, 0);
        build_exp(1'b0, 64'hFFFF_0000_ABCD_0001, 5'd5);
        check_eq("plan_w1", 64'(exp_q[1]), 64'h0000_0000_F2B5_79A5);
        run_seq(1'b0, 64'hFFFF_0000_ABCD_0001, 5'd5, 1, 3);
        run_seq(1'b1, 64'h0000_0000_0000_0007, 5'd31, -1, 0);
        run_seq(1'b1, 64'h0, 5'd3, 2, 2);

        // Reset mid-sequence after the first of three words is accepted.
        use_full = 1'b0;
        val_a = 1'b1; bus_val = 64'hFFFF_0000_ABCD_0001; rd = 5'd5;
        @(posedge clk); #1;
        val_a = 1'b0;
        check_eq("pre_rst_word", 64'(out_a), 64'h0000_0000_D280_0025);
        @(posedge clk); #1;
        check_eq("pre_rst_word2", 64'(out_a), 64'h0000_0000_F2B5_79A5);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("midrst_valid", 64'(valid_a), 64'd0);
        check_eq("midrst_rdy", 64'(rdy_a), 64'd1);
        check_eq("midrst_out", 64'(out_a), 64'd0);
        run_seq(1'b0, 64'h0000_1111_0000_2222, 5'd9, -1, 0);

        // Reset and ValIn together: request dropped.
        reset = 1'b1; val_a = 1'b1; bus_val = 64'h1234;
        @(posedge clk); #1;
        reset = 1'b0; val_a = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_wins_valid", 64'(valid_a), 64'd0);
        check_eq("rst_wins_rdy", 64'(rdy_a), 64'd1);

        // Random constants with sparse halfwords on both instances.
        for (int t = 0; t < 60; t++) begin
            rv = 64'h0;
            for (int i = 0; i < 4; i++) begin
                h = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
                rv = rv | (64'(h) << (16 * i));
            end
            run_seq(1'($urandom_range(0, 1)), rv, 5'($urandom),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                    int'($urandom_range(1, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/movwide_encoder.md
# movwide_encoder

Constant materializer for the LEGv8 datapath. It accepts a 64-bit constant and a destination register, then emits the shortest MOVZ/MOVK instruction sequence that loads that constant, one IM-format word per handshake. It produces the IM format (opcode[31:23], LSL hw[22:21], imm16[20:5], Rd[4:0]) that the wide-move path of the immediate extender decodes. It feeds the instruction-memory preload path and the program builder used by system-level benches.

## Interface
Parameters:
- SKIP_ZERO, default 1: when 1, halfwords equal to zero are not emitted (except the single MOVZ for value 0); when 0, always emit 4 words (MOVZ hw0, MOVK hw1..hw3).

Ports:
- CLK  input  1  clock; all state changes on rising edge
- Reset  input  1  synchronous, active-high reset
- ValIn  input  1  request valid
- RdyIn  output  1  encoder can accept a request
- BusVal  input  64  constant to materialize
- Rd  input  5  destination register; encoded verbatim, including 31
- InstrOut  output  32  encoded instruction
- InstrValid  output  1  InstrOut valid
- InstrReady  input  1  consumer accepts InstrOut
- InstrLast  output  1  current word is the last of the sequence
- Busy  output  1  sequence in progress (equals !RdyIn)

## Operation
- FSM states: IDLE and EMIT.
- IDLE:
  - RdyIn=1.
  - On ValIn&&RdyIn, register BusVal and Rd.
  - Compute mask NZ[3:0], where NZ[i] = (BusVal[16i+15:16i] != 0). With SKIP_ZERO=0, force NZ=4'b1111.
  - If NZ==0, force NZ=4'b0001 (emits MOVZ hw0, imm 0).
  - Set index = lowest set bit of NZ, first=1, then go to EMIT.
- EMIT:
  - InstrValid=1.
  - InstrOut = {first ? OPC_MOVZ : OPC_MOVK, index[1:0], val[16*index+15 -: 16], Rd}.
  - InstrLast=1 when no bit of NZ above index is set.
- On InstrValid&&InstrReady:
  - If not last: index = next set bit above index, first=0.
  - If last: go to IDLE.
- Opcodes: OPC_MOVZ = 9'b110100101 (base 0xD2800000); OPC_MOVK = 9'b111100101 (base 0xF2800000).
- Halfwords are emitted in ascending order. MOVZ is always the first word, so every sequence clears the upper halfwords.
- While not in IDLE, ValIn is ignored and the captured BusVal/Rd are not disturbed by input changes.

## Timing
- Reset values: state IDLE, InstrValid=0, InstrLast=0, InstrOut=32'h0, Busy=0, RdyIn=1. Captured value, Rd, NZ and index clear to 0.
- Latency: first word is valid the cycle after acceptance. Sequence length is popcount(NZ), from 1 to 4 words.
- With InstrReady held high, the next word is presented every cycle: a 4-word sequence occupies 4 consecutive EMIT cycles.
- Backpressure: while InstrValid && !InstrReady, InstrOut, InstrValid and InstrLast hold stable.
- After the last word is accepted, RdyIn=1 on the next cycle. No same-cycle accept on the final handshake, so there is a minimum 1-cycle IDLE gap between sequences.
- Reset mid-sequence: the sequence is abandoned. InstrValid=0 the next cycle and no partial words are replayed.
- Reset and ValIn asserted in the same cycle: reset wins and the request is not captured.
- InstrOut is don't-care when InstrValid=0, but the implementation drives 0.

## Structure
- Package movwide_pkg: OPC_MOVZ and OPC_MOVK, the state enum {IDLE, EMIT}, and the IM field positions (HW_LSB=21, IMM_LSB=5).
- One sub-module, hw_next_sel: combinational priority selector. Inputs are NZ[3:0] and the current index; outputs are the next index and a last flag. It is shared by the capture and advance paths.
- Everything else is registered state in movwide_encoder.

## Test plan
- BusVal=0, Rd=1 -> single word 0xD2800001, InstrLast=1.
- BusVal=0x0000_0000_0000_1234, Rd=2 -> single word 0xD2824682, InstrLast=1, RdyIn high 1 cycle after the handshake.
- BusVal=0x0001_0000_0000_0000, Rd=0 -> single word 0xD2E00020 (MOVZ with hw3).
- BusVal=0xFFFF_0000_ABCD_0001, Rd=5 -> three words: 0xD2800025, 0xF2B579A5, 0xF2FFFFE5. InstrLast only on the third. Hold InstrReady low for 3 cycles on the second word: it stays stable and no word is skipped.
- SKIP_ZERO=0, BusVal=0x0000_0000_0000_0007, Rd=31 -> four words: 0xD28000FF, 0xF2A0001F, 0xF2C0001F, 0xF2E0001F.
- Assert Reset after the first of three words is accepted -> InstrValid=0 next cycle and RdyIn=1. A new request then produces a clean sequence starting with MOVZ.
